kmeans_apb_regfile: RTL and testbench

// - APB slave register file for the K-means core, parametrised in centroid count and data width.
// - Holds the run configuration and the centroid bank, and launches the core with a GO pulse.
// - Tracks IDLE/BUSY/DONE state and the iteration count, and raises a maskable interrupt.
// - Sits between the APB stub and the K-means core; the core writes back centroids over a side port.

---
 rtl/kmeans_regs_pkg.sv | 28 ++
 rtl/kmeans_apb_regfile_if.sv | 24 ++
 rtl/kmeans_apb_fsm.sv | 62 ++++++
 rtl/kmeans_apb_regfile.sv | 152 +++++++++++++++
 tb/tb_kmeans_apb_regfile.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kmeans_regs_pkg.sv
// Shared types and register map for the K-means APB register file.
package kmeans_regs_pkg;

  // Run status as seen by software in STATUS[1:0].
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } status_e;

  // APB slave handshake phases.
  typedef enum logic [1:0] {
    SETUP = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2
  } apb_st_e;

  // Word addresses of the register map.
  localparam int REG_STATUS = 'h00;
  localparam int REG_GO     = 'h01;
  localparam int REG_FIRST  = 'h02;
  localparam int REG_LAST   = 'h03;
  localparam int REG_THR    = 'h04;
  localparam int REG_IRQ    = 'h05;
  localparam int REG_ITER   = 'h06;
  localparam int CENT_BASE  = 'h10;

endpackage

// File: rtl/kmeans_apb_regfile_if.sv
// APB bus bundle between the APB stub (master) and the register file (slave).
interface kmeans_apb_regfile_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 91
);
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/kmeans_apb_fsm.sv
// APB handshake: fixed SETUP -> WAIT -> RESP sequence with registered response.
module kmeans_apb_fsm
  import kmeans_regs_pkg::*;
#(
  parameter int DATA_W = 91
) (
  input  logic                clk,
  input  logic                rst,
  kmeans_apb_regfile_if.slave apb,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic                i_err,
  output logic                o_access
);

  apb_st_e           r_state;
  apb_st_e           w_next;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= SETUP;
    else     r_state <= w_next;
  end

  // Capture the decoded response at the end of the wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (r_state == WAIT) begin
      r_prdata  <= i_rdata;
      r_pslverr <= i_err;
    end
  end

  // Next state and bus outputs; prdata/pslverr only driven during the response cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    w_next      = r_state;
    o_access    = 1'b0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    case (r_state)
      SETUP: if (apb.psel && !apb.penable) w_next = WAIT;
      WAIT: begin
        o_access = 1'b1;
        w_next   = RESP;
      end
      RESP: begin
        apb.pready  = 1'b1;
        apb.prdata  = r_prdata;
        apb.pslverr = r_pslverr;
        w_next      = SETUP;
      end
      default: w_next = SETUP;
    endcase
  end

endmodule

// File: rtl/kmeans_apb_regfile.sv
// K-means APB register file: run configuration, centroid bank, run status and interrupt.
module kmeans_apb_regfile
  import kmeans_regs_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 91,
  parameter int NUM_CENT = 8,
  parameter int THR_W    = 16,
  parameter int ITER_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  kmeans_apb_regfile_if.slave        apb,
  output logic                       go_pulse,
  output logic [ADDR_W-1:0]          first_addr,
  output logic [ADDR_W-1:0]          last_addr,
  output logic [THR_W-1:0]           threshold,
  output logic [NUM_CENT*DATA_W-1:0] cent_flat,
  input  logic                       core_cent_we,
  input  logic [3:0]                 core_cent_idx,
  input  logic [DATA_W-1:0]          core_cent_wd,
  input  logic                       core_iter,
  input  logic                       core_done,
  output logic                       irq
);

  localparam int CIDX_W = (NUM_CENT > 1) ? $clog2(NUM_CENT) : 1;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
  localparam logic [ADDR_W-1:0] A_GO     = ADDR_W'(REG_GO);
  localparam logic [ADDR_W-1:0] A_FIRST  = ADDR_W'(REG_FIRST);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(REG_LAST);
  localparam logic [ADDR_W-1:0] A_THR    = ADDR_W'(REG_THR);
  localparam logic [ADDR_W-1:0] A_IRQ    = ADDR_W'(REG_IRQ);
  localparam logic [ADDR_W-1:0] A_ITER   = ADDR_W'(REG_ITER);
  localparam logic [ADDR_W-1:0] A_CENT   = ADDR_W'(CENT_BASE);

  status_e           r_status;
  logic [ITER_W-1:0] r_iter;
  logic              r_pending, r_irq_en, r_irq, r_go_pulse;
  logic [ADDR_W-1:0] r_first, r_last;
  logic [THR_W-1:0]  r_thr;
  logic [DATA_W-1:0] r_cent [NUM_CENT];

  logic              w_access, w_busy, w_err, w_cfg_we, w_cfg_err;
  logic              w_we_first, w_we_last, w_we_thr, w_we_irq, w_we_cent, w_start, w_go;
  logic              w_cent_hit, w_core_we;
  logic [ADDR_W-1:0] w_cent_off;
  logic [CIDX_W-1:0] w_cent_sel, w_core_sel;
  logic [DATA_W-1:0] w_rdata;

  kmeans_apb_fsm #(.DATA_W(DATA_W)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .apb      (apb),
    .i_rdata  (w_rdata),
    .i_err    (w_err),
    .o_access (w_access)
  );

  assign w_busy     = (r_status == BUSY);
  assign w_cfg_we   = apb.pwrite & ~w_busy;
  assign w_cfg_err  = apb.pwrite & w_busy;
  assign w_cent_off = apb.paddr - A_CENT;
  assign w_cent_hit = (apb.paddr >= A_CENT) && (int'(w_cent_off) < NUM_CENT);
  assign w_cent_sel = w_cent_off[CIDX_W-1:0];
  assign w_core_sel = core_cent_idx[CIDX_W-1:0];
  assign w_core_we  = core_cent_we && w_busy && (int'(core_cent_idx) < NUM_CENT);
  assign w_go       = w_access & w_start;

  // Address decode: read data, error flag and per-register write strobes.
  always_comb begin
    w_rdata    = '0;
    w_err      = 1'b0;
    w_we_first = 1'b0;
    w_we_last  = 1'b0;
    w_we_thr   = 1'b0;
    w_we_irq   = 1'b0;
    w_we_cent  = 1'b0;
    w_start    = 1'b0;
    if (w_cent_hit) begin
      w_rdata   = r_cent[w_cent_sel];
      w_we_cent = w_cfg_we;
      w_err     = w_cfg_err;
    end else begin
      case (apb.paddr)
        A_STATUS: begin w_rdata = DATA_W'(r_status); w_err = apb.pwrite; end
        A_GO:     begin w_start = w_cfg_we & apb.pwdata[0]; w_err = w_cfg_err; end
        A_FIRST:  begin w_rdata = DATA_W'(r_first); w_we_first = w_cfg_we; w_err = w_cfg_err; end
        A_LAST:   begin w_rdata = DATA_W'(r_last);  w_we_last  = w_cfg_we; w_err = w_cfg_err; end
        A_THR:    begin w_rdata = DATA_W'(r_thr);   w_we_thr   = w_cfg_we; w_err = w_cfg_err; end
        A_IRQ:    begin w_rdata = DATA_W'({r_irq_en, r_pending}); w_we_irq = apb.pwrite; end
        A_ITER:   begin w_rdata = DATA_W'(r_iter); w_err = apb.pwrite; end
        default:  w_err = 1'b1;
      endcase
    end
  end

  // Configuration and centroid storage: APB writes while not busy, core writeback while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first  <= '0;
      r_last   <= '0;
      r_thr    <= '0;
      r_irq_en <= 1'b0;
      // NOTE: the centroid bank is reset too, so an aborted run never leaves stale centroids visible.
      for (int i = 0; i < NUM_CENT; i++) r_cent[i] <= '0;
    end else begin
      if (w_access && w_we_first) r_first  <= apb.pwdata[ADDR_W-1:0];
      if (w_access && w_we_last)  r_last   <= apb.pwdata[ADDR_W-1:0];
      if (w_access && w_we_thr)   r_thr    <= apb.pwdata[THR_W-1:0];
      if (w_access && w_we_irq)   r_irq_en <= apb.pwdata[1];
      if (w_access && w_we_cent)  r_cent[w_cent_sel] <= apb.pwdata;
      if (w_core_we)              r_cent[w_core_sel] <= core_cent_wd;
    end
  end

  // Run status, iteration count, pending flag, GO pulse and registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status   <= IDLE;
      r_iter     <= '0;
      r_pending  <= 1'b0;
      r_go_pulse <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_go_pulse <= w_go;
      r_irq      <= r_pending & r_irq_en;
      if (w_go) begin
        r_status <= BUSY;
        r_iter   <= '0;
      end else if (w_busy) begin
        if (core_iter && (r_iter != '1)) r_iter <= r_iter + 1'b1;
        if (core_done) r_status <= DONE;
      end
      // Completion takes priority over a simultaneous software clear.
      if (w_go)                                          r_pending <= 1'b0;
      else if (w_busy && core_done)                      r_pending <= 1'b1;
      else if (w_access && w_we_irq && apb.pwdata[0])    r_pending <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CENT; g++) begin : g_flat
    assign cent_flat[g*DATA_W +: DATA_W] = r_cent[g];
  end

  assign go_pulse   = r_go_pulse;
  assign irq        = r_irq;
  assign first_addr = r_first;
  assign last_addr  = r_last;
  assign threshold  = r_thr;

endmodule

// File: tb/tb_kmeans_apb_regfile.sv
// Self-checking bench for kmeans_apb_regfile with a behavioural register-map model.
module tb_kmeans_apb_regfile;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 91;
  localparam int NUM_CENT = 8;
  localparam int THR_W    = 16;
  localparam int ITER_W   = 16;

  logic clk, rst;
  logic go_pulse, irq;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [THR_W-1:0] threshold;
  logic [NUM_CENT*DATA_W-1:0] cent_flat;
  logic core_cent_we, core_iter, core_done;
  logic [3:0] core_cent_idx;
  logic [DATA_W-1:0] core_cent_wd;

  kmeans_apb_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  kmeans_apb_regfile #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CENT(NUM_CENT), .THR_W(THR_W), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb), .go_pulse(go_pulse),
    .first_addr(first_addr), .last_addr(last_addr), .threshold(threshold), .cent_flat(cent_flat),
    .core_cent_we(core_cent_we), .core_cent_idx(core_cent_idx), .core_cent_wd(core_cent_wd),
    .core_iter(core_iter), .core_done(core_done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: software-visible state of the register map.
  int                m_status;   // 0 idle, 1 busy, 2 done
  int                m_iter;
  bit                m_pending, m_irq_en;
  int                m_first, m_last, m_thr;
  logic [DATA_W-1:0] m_cent [NUM_CENT];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_status = 0; m_iter = 0; m_pending = 0; m_irq_en = 0;
    m_first = 0; m_last = 0; m_thr = 0;
    for (int i = 0; i < NUM_CENT; i++) m_cent[i] = '0;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  // Expected outcome of one APB access; race_done models core_done in the access cycle.
  function automatic void model_access(input bit wr, input int addr, input logic [DATA_W-1:0] wd,
                                       input bit race_done, output logic [DATA_W-1:0] rd,
                                       output bit err, output bit go);
    bit busy;
    busy = (m_status == 1);
    rd = '0; err = 0; go = 0;
    if (addr >= 'h10 && addr < 'h10 + NUM_CENT) begin
      if (!wr) rd = m_cent[addr - 'h10];
      else if (busy) err = 1;
      else m_cent[addr - 'h10] = wd;
    end else begin
      case (addr)
        'h00: if (wr) err = 1; else rd = DATA_W'(m_status);
        'h01: if (wr) begin
                if (busy) err = 1;
                else if (wd[0]) begin go = 1; m_status = 1; m_iter = 0; m_pending = 0; end
              end
        'h02: if (!wr) rd = DATA_W'(m_first); else if (busy) err = 1; else m_first = int'(wd[ADDR_W-1:0]);
        'h03: if (!wr) rd = DATA_W'(m_last);  else if (busy) err = 1; else m_last  = int'(wd[ADDR_W-1:0]);
        'h04: if (!wr) rd = DATA_W'(m_thr);   else if (busy) err = 1; else m_thr   = int'(wd[THR_W-1:0]);
        'h05: if (wr) begin
                if (wd[0]) m_pending = 0;
                m_irq_en = wd[1];
              end else rd = DATA_W'({m_irq_en, m_pending});
        'h06: if (wr) err = 1; else rd = DATA_W'(m_iter);
        default: err = 1;
      endcase
    end
    if (race_done && busy) begin m_status = 2; m_pending = 1; end
  endfunction

  // One APB transfer; checks the 3-cycle handshake and single-cycle pready.
  task automatic apb_xfer(input bit wr, input int addr, input logic [DATA_W-1:0] wd, input bit race_done,
                          output logic [DATA_W-1:0] rd, output logic err,
                          output logic go_seen, output logic go_after);
    int waits;
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = ADDR_W'(addr); apb.pwdata = wd;
    @(negedge clk);
    apb.penable = 1'b1;
    if (race_done) core_done = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      waits++;
      core_done = 1'b0;
      if (apb.pready === 1'b1 || waits >= 8) break;
    end
    check("pready_latency", 128'(waits), 128'(1));
    rd = apb.prdata; err = apb.pslverr; go_seen = go_pulse;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", 128'(apb.pready), 128'(0));
    check("prdata_idle_zero", 128'(apb.prdata), 128'(0));
    go_after = go_pulse;
  endtask

  task automatic access(input string tag, input bit wr, input int addr,
                        input logic [DATA_W-1:0] wd, input bit race_done);
    logic [DATA_W-1:0] rd, erd;
    logic err, gs, ga;
    bit eerr, ego;
    model_access(wr, addr, wd, race_done, erd, eerr, ego);
    apb_xfer(wr, addr, wd, race_done, rd, err, gs, ga);
    check({tag, "_err"}, 128'(err), 128'(eerr));
    if (!wr) check({tag, "_rdata"}, 128'(rd), 128'(erd));
    check({tag, "_go"}, 128'(gs), 128'(ego));
    check({tag, "_go_after"}, 128'(ga), 128'(0));
  endtask

  task automatic core_iter_pulse();
    @(negedge clk) core_iter = 1'b1;
    @(negedge clk) core_iter = 1'b0;
    if (m_status == 1 && m_iter < (1 << ITER_W) - 1) m_iter++;
  endtask

  task automatic core_done_pulse();
    @(negedge clk) core_done = 1'b1;
    @(negedge clk) core_done = 1'b0;
    if (m_status == 1) begin m_status = 2; m_pending = 1; end
  endtask

  task automatic core_wr(input int idx, input logic [DATA_W-1:0] d);
    @(negedge clk);
    core_cent_we = 1'b1; core_cent_idx = 4'(idx); core_cent_wd = d;
    @(negedge clk);
    core_cent_we = 1'b0;
    if (m_status == 1 && idx < NUM_CENT) m_cent[idx] = d;
  endtask

  // Settled comparison of the core-facing outputs against the model.
  task automatic check_outputs(input string tag);
    @(negedge clk);
    check({tag, "_first"}, 128'(first_addr), 128'(m_first));
    check({tag, "_last"},  128'(last_addr),  128'(m_last));
    check({tag, "_thr"},   128'(threshold),  128'(m_thr));
    check({tag, "_irq"},   128'(irq),        128'(m_pending & m_irq_en));
    check({tag, "_go"},    128'(go_pulse),   128'(0));
    for (int i = 0; i < NUM_CENT; i++)
      check({tag, "_cent"}, 128'(cent_flat[i*DATA_W +: DATA_W]), 128'(m_cent[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n_it, a;
    logic [DATA_W-1:0] d;

    rst = 1'b1;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    core_cent_we = 0; core_cent_idx = '0; core_cent_wd = '0; core_iter = 0; core_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_pready", 128'(apb.pready), 128'(0));
    check("reset_pslverr", 128'(apb.pslverr), 128'(0));
    check_outputs("reset");
    access("reset_status", 0, 'h00, '0, 0);

    // Configuration round-trip with directed and random centroid values.
    access("thr_w",   1, 'h04, DATA_W'('h1234), 0);
    access("first_w", 1, 'h02, DATA_W'('h005), 0);
    access("last_w",  1, 'h03, DATA_W'('h1FF), 0);
    access("cent7_w", 1, 'h17, DATA_W'('h5A5), 0);
    for (int i = 0; i < NUM_CENT - 1; i++) access("centr_w", 1, 'h10 + i, rand_data(), 0);
    access("thr_r",   0, 'h04, '0, 0);
    access("first_r", 0, 'h02, '0, 0);
    access("last_r",  0, 'h03, '0, 0);
    for (int i = 0; i < NUM_CENT; i++) access("cent_r", 0, 'h10 + i, '0, 0);
    check_outputs("cfg");

    // Run flow: enable irq, GO, three iterations, completion.
    access("irqen_w", 1, 'h05, DATA_W'('h2), 0);
    access("go_idle", 1, 'h01, DATA_W'('h1), 0);
    access("status_busy", 0, 'h00, '0, 0);
    repeat (3) core_iter_pulse();
    core_done_pulse();
    check("irq_latency", 128'(irq), 128'(0));
    check_outputs("done");
    access("status_done", 0, 'h00, '0, 0);
    access("iter_r",      0, 'h06, '0, 0);
    access("irq_r",       0, 'h05, '0, 0);
    access("irq_w1c",     1, 'h05, DATA_W'('h3), 0);
    check_outputs("w1c");

    // Busy protection on a second run with a random iteration count.
    access("go_done", 1, 'h01, DATA_W'('h1), 0);
    n_it = int'($urandom_range(1, 6));
    repeat (n_it) core_iter_pulse();
    access("busy_cent0_w", 1, 'h10, rand_data(), 0);
    access("busy_go_w",    1, 'h01, DATA_W'('h1), 0);
    access("busy_thr_w",   1, 'h04, rand_data(), 0);
    access("busy_first_w", 1, 'h02, rand_data(), 0);
    access("ro_status_w",  1, 'h00, DATA_W'('h2), 0);
    access("ro_iter_w",    1, 'h06, DATA_W'('h9), 0);
    access("busy_cent0_r", 0, 'h10, '0, 0);
    access("busy_iter_r",  0, 'h06, '0, 0);

    // Core writeback, including an out-of-range index.
    core_wr(2, DATA_W'('h77));
    core_wr(NUM_CENT, rand_data());
    for (int i = 0; i < 4; i++) core_wr(int'($urandom_range(0, 15)), rand_data());
    access("wb_cent2_r", 0, 'h12, '0, 0);
    for (int i = 0; i < NUM_CENT; i++) access("wb_cent_r", 0, 'h10 + i, '0, 0);
    check_outputs("wb");

    // Unmapped addresses.
    access("unmapped_0f", 0, 'h0F, '0, 0);
    access("unmapped_end", 0, 'h10 + NUM_CENT, '0, 0);
    for (int i = 0; i < 4; i++) begin
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(7, 15))
                                      : int'($urandom_range(16 + NUM_CENT, 511));
      access("unmapped_rnd", 0, a, '0, 0);
    end

    // Completion in the same cycle as a W1C of pending: the set wins.
    access("race_w1c", 1, 'h05, DATA_W'('h3), 1);
    access("race_irq_r", 0, 'h05, '0, 0);
    access("race_status", 0, 'h00, '0, 0);
    check_outputs("race");

    // Core strobes while not busy are ignored.
    core_iter_pulse();
    core_done_pulse();
    d = rand_data();
    core_wr(1, d);
    access("idle_iter_r", 0, 'h06, '0, 0);
    access("idle_cent1_r", 0, 'h11, '0, 0);

    // Reset in the middle of a run and of a transfer.
    access("go_abort", 1, 'h01, DATA_W'('h1), 0);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = ADDR_W'('h04); apb.pwdata = DATA_W'('hBEEF);
    @(negedge clk);
    apb.penable = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_pready",  128'(apb.pready),  128'(0));
    check("rst_prdata",  128'(apb.prdata),  128'(0));
    check("rst_pslverr", 128'(apb.pslverr), 128'(0));
    check("rst_go",      128'(go_pulse),    128'(0));
    check("rst_irq",     128'(irq),         128'(0));
    check("rst_first",   128'(first_addr),  128'(0));
    check("rst_thr",     128'(threshold),   128'(0));
    check("rst_cent",    128'(cent_flat),   128'(0));
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access("post_rst_status", 0, 'h00, '0, 0);
    access("post_rst_thr",    0, 'h04, '0, 0);
    access("post_rst_irq",    0, 'h05, '0, 0);
    access("post_rst_cent7",  0, 'h17, '0, 0);
    check_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
